// File: rtl/glitch_filter.sv
// Debounces a raw, asynchronous level: it is synchronized, then accepted only after
// holding for STABLE_CYCLES samples. Edge and glitch events are counted with saturation.
module glitch_filter #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             w_in,
  input  logic             en,
  input  logic             clr_cnt,
  output logic             w_clean,
  output logic             rise,
  output logic             fall,
  output logic             glitch,
  output logic             busy,
  output logic [CNT_W-1:0] edge_cnt,
  output logic [CNT_W-1:0] glitch_cnt
);

  localparam int unsigned      STAB_W    = $clog2(STABLE_CYCLES);
  localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE_LO = 2'd0,
    PEND_HI = 2'd1,
    IDLE_HI = 2'd2,
    PEND_LO = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [STAB_W-1:0]   stab_q, stab_d;
  logic                sync1_q, sync1_d;
  logic                sync2_q, sync2_d;
  logic                rise_q, rise_d;
  logic                fall_q, fall_d;
  logic                glitch_q, glitch_d;
  logic [CNT_W-1:0]    edge_cnt_q, edge_cnt_d;
  logic [CNT_W-1:0]    glitch_cnt_q, glitch_cnt_d;
  logic                w_sync;

  assign w_sync = sync2_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE_LO;
      stab_q       <= '0;
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      rise_q       <= 1'b0;
      fall_q       <= 1'b0;
      glitch_q     <= 1'b0;
      edge_cnt_q   <= '0;
      glitch_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      stab_q       <= stab_d;
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      rise_q       <= rise_d;
      fall_q       <= fall_d;
      glitch_q     <= glitch_d;
      edge_cnt_q   <= edge_cnt_d;
      glitch_cnt_q <= glitch_cnt_d;
    end
  end

  // Qualification FSM; a disable abandons a pending change silently.
  always_comb begin
    state_d  = state_q;
    stab_d   = stab_q;
    sync1_d  = w_in;
    sync2_d  = sync1_q;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    glitch_d = 1'b0;
    case (state_q)
      IDLE_LO: begin
        if (en && w_sync) begin
          state_d = PEND_HI;
          stab_d  = STAB_W'(1);
        end
      end
      PEND_HI: begin
        if (!en) begin
          state_d = IDLE_LO;
          stab_d  = '0;
        end else if (w_sync) begin
          if (stab_q == STAB_LAST) begin
            state_d = IDLE_HI;
            stab_d  = '0;
            rise_d  = 1'b1;
          end else begin
            stab_d = stab_q + STAB_W'(1);
          end
        end else begin
          state_d  = IDLE_LO;
          stab_d   = '0;
          glitch_d = 1'b1;
        end
      end
      IDLE_HI: begin
        if (en && !w_sync) begin
          state_d = PEND_LO;
          stab_d  = STAB_W'(1);
        end
      end
      PEND_LO: begin
        if (!en) begin
          state_d = IDLE_HI;
          stab_d  = '0;
        end else if (!w_sync) begin
          if (stab_q == STAB_LAST) begin
            state_d = IDLE_LO;
            stab_d  = '0;
            fall_d  = 1'b1;
          end else begin
            stab_d = stab_q + STAB_W'(1);
          end
        end else begin
          state_d  = IDLE_HI;
          stab_d   = '0;
          glitch_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE_LO;
        stab_d  = '0;
      end
    endcase
  end

  // Counters advance while the pulse is visible, so a clear in that cycle wins.
  always_comb begin
    edge_cnt_d   = edge_cnt_q;
    glitch_cnt_d = glitch_cnt_q;
    if (clr_cnt) begin
      edge_cnt_d   = '0;
      glitch_cnt_d = '0;
    end else begin
      if ((rise_q || fall_q) && (edge_cnt_q != CNT_MAX)) begin
        edge_cnt_d = edge_cnt_q + CNT_W'(1);
      end
      if (glitch_q && (glitch_cnt_q != CNT_MAX)) begin
        glitch_cnt_d = glitch_cnt_q + CNT_W'(1);
      end
    end
  end

  assign w_clean    = (state_q == IDLE_HI) || (state_q == PEND_LO);
  assign busy       = (state_q == PEND_HI) || (state_q == PEND_LO);
  assign rise       = rise_q;
  assign fall       = fall_q;
  assign glitch     = glitch_q;
  assign edge_cnt   = edge_cnt_q;
  assign glitch_cnt = glitch_cnt_q;

endmodule

// File: tb/tb_glitch_filter.sv
// Randomized and directed bench for glitch_filter: a level/run-length reference model
// predicts every cycle's outputs into a queue that a negedge monitor drains and compares.
module tb_glitch_filter;

  localparam int unsigned S   = 4;
  localparam int          MX1 = 255;
  localparam int          MX2 = 3;

  logic clk = 1'b0;
  logic rst_n, w_in, en, clr_cnt;
  logic w_clean, rise, fall, glitch, busy;
  logic [7:0] edge_cnt, glitch_cnt;
  logic w_clean2, rise2, fall2, glitch2, busy2;
  logic [1:0] edge_cnt2, glitch_cnt2;

  always #5 clk = ~clk;

  glitch_filter #(.STABLE_CYCLES(S), .CNT_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .w_in(w_in), .en(en), .clr_cnt(clr_cnt),
    .w_clean(w_clean), .rise(rise), .fall(fall), .glitch(glitch), .busy(busy),
    .edge_cnt(edge_cnt), .glitch_cnt(glitch_cnt)
  );

  glitch_filter #(.STABLE_CYCLES(S), .CNT_W(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .w_in(w_in), .en(en), .clr_cnt(clr_cnt),
    .w_clean(w_clean2), .rise(rise2), .fall(fall2), .glitch(glitch2), .busy(busy2),
    .edge_cnt(edge_cnt2), .glitch_cnt(glitch_cnt2)
  );

  typedef struct packed {
    logic       w_clean;
    logic       rise;
    logic       fall;
    logic       glitch;
    logic       busy;
    logic [7:0] ecnt;
    logic [7:0] gcnt;
    logic [1:0] ecnt2;
    logic [1:0] gcnt2;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: last two raw samples, accepted level, pending run length.
  logic m_s1, m_s2, m_clean, m_pend, m_rise, m_fall, m_gl;
  int   m_run, ec, gc, ec2, gc2;

  task automatic model_edge(input logic r, input logic w, input logic e, input logic c);
    logic ws, ev_e, ev_g;
    if (!r) begin
      m_s1 = 0; m_s2 = 0; m_clean = 0; m_pend = 0; m_run = 0;
      m_rise = 0; m_fall = 0; m_gl = 0;
      ec = 0; gc = 0; ec2 = 0; gc2 = 0;
    end else begin
      ws   = m_s2;
      ev_e = m_rise | m_fall;
      ev_g = m_gl;
      if (c) begin
        ec = 0; gc = 0; ec2 = 0; gc2 = 0;
      end else begin
        if (ev_e) begin
          if (ec < MX1) ec++;
          if (ec2 < MX2) ec2++;
        end
        if (ev_g) begin
          if (gc < MX1) gc++;
          if (gc2 < MX2) gc2++;
        end
      end
      m_rise = 0; m_fall = 0; m_gl = 0;
      if (!e) begin
        m_pend = 0; m_run = 0;
      end else if (ws != m_clean) begin
        if (!m_pend) begin
          m_pend = 1; m_run = 1;
        end else if (m_run == int'(S) - 1) begin
          m_clean = ws; m_pend = 0; m_run = 0;
          if (ws) m_rise = 1; else m_fall = 1;
        end else begin
          m_run++;
        end
      end else if (m_pend) begin
        m_pend = 0; m_run = 0; m_gl = 1;
      end
      m_s2 = m_s1;
      m_s1 = w;
    end
  endtask

  task automatic step(input logic r, input logic w, input logic e, input logic c);
    exp_t x;
    rst_n = r; w_in = w; en = e; clr_cnt = c;
    model_edge(r, w, e, c);
    x.w_clean = m_clean; x.rise = m_rise; x.fall = m_fall; x.glitch = m_gl;
    x.busy = m_pend; x.ecnt = 8'(ec); x.gcnt = 8'(gc); x.ecnt2 = 2'(ec2); x.gcnt2 = 2'(gc2);
    exp_q.push_back(x);
    @(posedge clk);
    #1;
  endtask

  task automatic hold(input logic w, input int n);
    for (int i = 0; i < n; i++) step(1'b1, w, 1'b1, 1'b0);
  endtask

  // Monitor: one expected record per clock edge, compared on the falling edge.
  initial begin
    exp_t x, g;
    int   cyc;
    cyc = 0;
    @(posedge clk);
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        g.w_clean = w_clean; g.rise = rise; g.fall = fall; g.glitch = glitch; g.busy = busy;
        g.ecnt = edge_cnt; g.gcnt = glitch_cnt; g.ecnt2 = edge_cnt2; g.gcnt2 = glitch_cnt2;
        checks++;
        if (g !== x) begin
          errors++;
          $display("FAIL cyc%0d outputs got clean=%b r=%b f=%b g=%b busy=%b ec=%0d gc=%0d ec2=%0d gc2=%0d exp clean=%b r=%b f=%b g=%b busy=%b ec=%0d gc=%0d ec2=%0d gc2=%0d",
                   cyc, g.w_clean, g.rise, g.fall, g.glitch, g.busy, g.ecnt, g.gcnt, g.ecnt2, g.gcnt2,
                   x.w_clean, x.rise, x.fall, x.glitch, x.busy, x.ecnt, x.gcnt, x.ecnt2, x.gcnt2);
        end
        checks++;
        if ((int'(rise) + int'(fall) + int'(glitch)) > 1 ||
            (w_clean2 !== w_clean) || (busy2 !== busy) || (rise2 !== rise) ||
            (fall2 !== fall) || (glitch2 !== glitch)) begin
          errors++;
          $display("FAIL cyc%0d pulses got r=%b f=%b g=%b r2=%b f2=%b g2=%b clean2=%b busy2=%b exp exclusive and equal across widths",
                   cyc, rise, fall, glitch, rise2, fall2, glitch2, w_clean2, busy2);
        end
        cyc++;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout got running exp finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic lvl, r, e, c;
    int   len;
    rst_n = 0; w_in = 0; en = 0; clr_cnt = 0;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b0);
    // Clean rise then fall.
    hold(1'b0, 3);
    hold(1'b1, 10);
    hold(1'b0, 10);
    // Three-cycle pulse is rejected as a glitch.
    hold(1'b1, 3);
    hold(1'b0, 8);
    // Five accepted transitions saturate the narrow counter.
    for (int k = 0; k < 5; k++) hold(k % 2 == 0, 8);
    hold(1'b0, 10);
    for (int i = 0; i < 20 && !m_rise; i++) step(1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    hold(1'b1, 3);
    // Disable mid-qualification, then full re-qualification.
    hold(1'b0, 10);
    hold(1'b1, 4);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    hold(1'b1, 10);
    // Reset during a pending fall.
    hold(1'b0, 4);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    hold(1'b0, 8);
    // High input across reset release is treated as a new rise.
    hold(1'b1, 8);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    hold(1'b1, 10);
    // Random runs of both levels with sporadic disable, clear and reset.
    lvl = 1'b1;
    for (int k = 0; k < 600; k++) begin
      lvl = ~lvl;
      len = $urandom_range(1, 8);
      for (int i = 0; i < len; i++) begin
        r = ($urandom_range(0, 200) != 0);
        e = ($urandom_range(0, 15) != 0);
        c = ($urandom_range(0, 40) == 0);
        step(r, lvl, e, c);
      end
    end
    hold(1'b0, 4);
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain got %0d pending exp 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/glitch_filter.md
GLITCH_FILTER -- requirements
Module: glitch_filter

Interface
REQ-001 Parameter STABLE_CYCLES, default 4, SHALL set the consecutive-cycle count a new level must hold before acceptance; legal range 2..255.
REQ-002 Parameter CNT_W, default 8, SHALL set the width of both event counters.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  SHALL be the synchronous, active-low reset, sampled on rising clk.
REQ-005 w_in  input  1  SHALL carry the raw, asynchronous output of the upstream gate network (may glitch).
REQ-006 en  input  1  SHALL enable filtering when 1.
REQ-007 clr_cnt  input  1  SHALL synchronously clear both counters when 1.
REQ-008 w_clean  output  1  SHALL carry the debounced level.
REQ-009 rise  output  1  SHALL pulse one cycle when w_clean goes 0->1.
REQ-010 fall  output  1  SHALL pulse one cycle when w_clean goes 1->0.
REQ-011 glitch  output  1  SHALL pulse one cycle when a pending change is abandoned.
REQ-012 busy  output  1  SHALL be 1 while a change is pending.
REQ-013 edge_cnt  output  CNT_W  SHALL count accepted transitions (rise + fall).
REQ-014 glitch_cnt  output  CNT_W  SHALL count glitch pulses.

Function
REQ-015 w_in SHALL pass through a 2-flop synchronizer; second flop output is w_sync; FSM uses only w_sync.
REQ-016 FSM states SHALL be IDLE_LO, PEND_HI, IDLE_HI, PEND_LO; w_clean = 1 exactly in IDLE_HI and PEND_LO.
REQ-017 IDLE_LO, w_sync=1, en=1 -> PEND_HI, stable counter = 1; IDLE_HI, w_sync=0, en=1 -> PEND_LO, stable counter = 1.
REQ-018 PEND_x with w_sync at target level: counter increments; on the edge where counter = STABLE_CYCLES-1 and w_sync still at target, SHALL move to IDLE_x (target) and pulse rise/fall that same cycle.
REQ-019 Latency: w_in stable for STABLE_CYCLES+2 edges -> w_clean updates after edge STABLE_CYCLES+2 (default 6); shorter pulses SHALL never reach w_clean.
REQ-020 PEND_x with w_sync back at the old level: SHALL return to the originating IDLE state, clear counter, pulse glitch one cycle.
REQ-021 busy SHALL be 1 exactly in PEND_HI and PEND_LO.
REQ-022 en=0: synchronizer keeps running; PEND states SHALL return to their IDLE state without glitch pulse; IDLE states hold; no rise/fall/glitch pulses; counters hold.
REQ-023 edge_cnt SHALL increment on each rise or fall pulse; glitch_cnt on each glitch pulse; both SHALL saturate at 2^CNT_W-1 (no wrap).
REQ-024 clr_cnt=1 SHALL clear both counters, taking priority over a simultaneous increment.
REQ-025 rise, fall, glitch SHALL be mutually exclusive in any cycle.

Reset
REQ-026 rst_n=0 at a rising edge SHALL force: sync flops 0, state IDLE_LO, stable counter 0, w_clean 0, rise/fall/glitch/busy 0, edge_cnt 0, glitch_cnt 0.
REQ-027 Reset SHALL override en and clr_cnt and SHALL abort any pending change with no pulse.
REQ-028 If w_in = 1 after reset release, the block SHALL treat it as a new rise (IDLE_LO -> PEND_HI) and accept it per REQ-019.

Verification
REQ-029 Default params, w_in 0->1 held 10 cycles -> w_clean 1 after edge 6, rise pulsed once, edge_cnt=1, busy high 3 cycles.
REQ-030 w_in high for 3 cycles then 0 -> w_clean stays 0, one glitch pulse, glitch_cnt=1, edge_cnt=0.
REQ-031 CNT_W=2, 5 accepted transitions -> edge_cnt saturates at 3; then clr_cnt during a rise pulse -> edge_cnt=0 next cycle.
REQ-032 en=0 mid-PEND_HI -> busy drops next edge, no glitch, w_clean 0; en=1 with w_in still 1 -> full STABLE_CYCLES re-qualification.
REQ-033 rst_n=0 during PEND_LO with w_clean=1 -> next edge w_clean=0, all counters 0, no fall pulse.
